// File: rtl/conv_mc_filter.sv
// Multi-channel convolution filter: one kernel tap across CH channels per beat,
// KTAPS beats per window, then bias, round, shift, optional ReLU and saturate.

module conv_mc_lane #(
  parameter int ACT_W = 6,
  parameter int W_W   = 8,
  parameter int ACC_W = 24
) (
  input  logic        [ACT_W-1:0] act,
  input  logic signed [W_W-1:0]   wgt,
  output logic signed [ACC_W-1:0] prod
);
  logic signed [ACT_W+W_W:0] p;

  // Activation is unsigned: a zero MSB keeps it positive in the signed multiply.
  assign p    = $signed({1'b0, act}) * wgt;
  assign prod = ACC_W'(p);
endmodule

module conv_mc_filter #(
  parameter int CH     = 3,
  parameter int KTAPS  = 9,
  parameter int ACT_W  = 6,
  parameter int W_W    = 8,
  parameter int BIAS_W = 20,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 7,
  parameter int OUT_W  = 13
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     relu_en,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*ACT_W-1:0]      in_act,
  input  logic [CH*W_W-1:0]        in_wgt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     busy
);
  localparam int TC_W = (KTAPS > 1) ? $clog2(KTAPS) : 1;
  localparam logic [TC_W-1:0]      LAST_TAP = TC_W'(KTAPS - 1);
  localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W:0] OMAX   = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W:0] OMIN   = -((ACC_W+1)'(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_FINAL, S_OUT} state_t;

  state_t state_q, state_d;
  logic [TC_W-1:0]         tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0] prod_q, prod_d;
  logic                    prod_v_q, prod_v_d;
  logic                    first_q, first_d;
  logic signed [ACC_W-1:0] bias_q, bias_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic [CH-1:0][ACC_W-1:0] lane_prod;
  logic signed [ACC_W-1:0]  psum;
  logic signed [ACC_W:0]    rnd, sh;
  logic                     accept;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    conv_mc_lane #(.ACT_W(ACT_W), .W_W(W_W), .ACC_W(ACC_W)) u_lane (
      .act  (in_act[c*ACT_W +: ACT_W]),
      .wgt  (in_wgt[c*W_W +: W_W]),
      .prod (lane_prod[c])
    );
  end

  always_comb begin
    psum = '0;
    for (int c = 0; c < CH; c++) psum = psum + $signed(lane_prod[c]);
  end

  assign accept = in_valid & in_ready & ~clear;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst) state_q <= S_ACC;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (accept && tap_cnt_q == LAST_TAP) state_d = S_DRAIN;
      S_DRAIN: state_d = S_FINAL;
      S_FINAL: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
    if (clear) state_d = S_ACC;
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == S_ACC);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_ACC) || (tap_cnt_q != '0);
  end

  // Round half up with one guard bit so the +2^(SHIFT-1) cannot wrap.
  always_comb begin
    rnd = {acc_q[ACC_W-1], acc_q} + RND;
    sh  = rnd >>> SHIFT;
    if (relu_en && sh[ACC_W]) sh = '0;
  end

  always_comb begin
    tap_cnt_d  = tap_cnt_q;
    prod_d     = prod_q;
    prod_v_d   = accept;
    first_d    = first_q;
    bias_d     = bias_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    if (accept) begin
      tap_cnt_d = (tap_cnt_q == LAST_TAP) ? '0 : tap_cnt_q + 1'b1;
      prod_d    = psum;
      first_d   = (tap_cnt_q == '0);
      if (tap_cnt_q == '0) bias_d = ACC_W'(bias);
    end

    // Accumulator lags the product register by one edge; overflow wraps.
    if (prod_v_q && !clear) acc_d = (first_q ? bias_q : acc_q) + prod_q;

    if (state_q == S_FINAL && !clear) begin
      if (sh > OMAX) begin
        out_data_d = OMAX[OUT_W-1:0];
        out_sat_d  = 1'b1;
      end else if (sh < OMIN) begin
        out_data_d = OMIN[OUT_W-1:0];
        out_sat_d  = 1'b1;
      end else begin
        out_data_d = sh[OUT_W-1:0];
        out_sat_d  = 1'b0;
      end
    end

    if (clear) tap_cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      tap_cnt_q  <= '0;
      prod_q     <= '0;
      prod_v_q   <= 1'b0;
      first_q    <= 1'b0;
      bias_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      tap_cnt_q  <= tap_cnt_d;
      prod_q     <= prod_d;
      prod_v_q   <= prod_v_d;
      first_q    <= first_d;
      bias_q     <= bias_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;
endmodule
